// File: rtl/i2c_seq_pkg.sv
// Shared types and default timing constants for the I2C transaction sequencer.
package i2c_seq_pkg;

    localparam int unsigned TMR_W         = 13;
    localparam int unsigned GAP_CYC_DEF   = 40;
    localparam int unsigned TOUT_CYC_DEF  = 4096;
    localparam int unsigned MAX_RETRY_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_EN,
        WAIT_DONE,
        GAP,
        RESP
    } seq_state_t;

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable saturating down-counter; shared by the bus-free gap and the hang timeout.
module i2c_seq_timer
    import i2c_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_master_seq.sv
// Request/response sequencer in front of the I2C master: launch, retry on NACK,
// bus-free gap and hang timeout.
module i2c_master_seq
    import i2c_seq_pkg::*;
#(
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF,
    parameter int unsigned TOUT_CYC  = TOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic       req_rw,
    input  logic [6:0] req_sadr,
    input  logic [7:0] req_radr,
    input  logic [7:0] req_wdat,
    output logic       rsp_vld,
    input  logic       rsp_rdy,
    output logic [7:0] rsp_dat,
    output logic       rsp_nack,
    output logic       rsp_tout,
    output logic [1:0] rsp_try,
    output logic       busy,
    output logic       st,
    output logic [7:0] ADR_COM,
    output logic [7:0] adr_REG,
    output logic [7:0] dat_REG,
    input  logic       en_tx,
    input  logic       err_AC,
    input  logic [7:0] RX_dat
);

    localparam logic [TMR_W-1:0] TOUT_LD = TMR_W'(TOUT_CYC);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYC - 1);

    seq_state_t       state, state_nxt;
    logic [1:0]       try_cnt;
    logic             nack_r, tout_r;
    logic [7:0]       rx_r;
    logic             accept, capture, timeout, retry;
    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    i2c_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, start pulse and timer control. en_tx edges take priority over timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        retry     = 1'b0;
        st        = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = TOUT_LD;
        case (state)
            IDLE: begin
                if (req_vld && req_rdy) begin
                    accept    = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                // Hold off the pulse (and keep the timeout fresh) while the master is still busy.
                if (!en_tx) begin
                    st        = 1'b1;
                    state_nxt = WAIT_EN;
                end else begin
                    tmr_load = 1'b1;
                end
            end
            WAIT_EN: begin
                if (en_tx) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr_zero) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WAIT_DONE: begin
                if (!en_tx) begin
                    capture   = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LD;
                    state_nxt = GAP;
                end else if (tmr_zero) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if (nack_r && (32'(try_cnt) < MAX_RETRY)) begin
                        retry     = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = LAUNCH;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields, attempt count and per-attempt result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            try_cnt <= '0;
            nack_r  <= 1'b0;
            tout_r  <= 1'b0;
            rx_r    <= '0;
            ADR_COM <= '0;
            adr_REG <= '0;
            dat_REG <= '0;
        end else begin
            if (accept) begin
                ADR_COM <= {req_sadr, req_rw};
                adr_REG <= req_radr;
                dat_REG <= req_wdat;
                try_cnt <= '0;
                nack_r  <= 1'b0;
                tout_r  <= 1'b0;
            end
            if (capture) begin
                nack_r <= err_AC;
                rx_r   <= RX_dat;
            end
            if (timeout) begin
                tout_r <= 1'b1;
                nack_r <= 1'b0;
            end
            if (retry) begin
                try_cnt <= try_cnt + 2'd1;
            end
        end
    end

    assign req_rdy  = (state == IDLE) && !en_tx && !rst;
    assign busy     = (state != IDLE);
    assign rsp_vld  = (state == RESP);
    assign rsp_nack = rsp_vld && nack_r;
    assign rsp_tout = rsp_vld && tout_r;
    assign rsp_try  = rsp_vld ? try_cnt : 2'd0;
    assign rsp_dat  = (rsp_vld && ADR_COM[0] && !nack_r && !tout_r) ? rx_r : 8'h00;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Self-checking bench for i2c_master_seq with a behavioural I2C master model.
module tb_i2c_master_seq;

    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned GAP_CYC   = 40;
    localparam int unsigned TOUT_CYC  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vld = 1'b0, req_rdy, req_rw = 1'b0;
    logic [6:0] req_sadr = '0;
    logic [7:0] req_radr = '0, req_wdat = '0;
    logic       rsp_vld, rsp_rdy = 1'b0, rsp_nack, rsp_tout, busy, st;
    logic [7:0] rsp_dat, ADR_COM, adr_REG, dat_REG;
    logic [1:0] rsp_try;
    logic       en_tx = 1'b0, err_AC = 1'b0;
    logic [7:0] RX_dat = '0;

    i2c_master_seq #(
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYC   (GAP_CYC),
        .TOUT_CYC  (TOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_rw   (req_rw),
        .req_sadr (req_sadr),
        .req_radr (req_radr),
        .req_wdat (req_wdat),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_dat  (rsp_dat),
        .rsp_nack (rsp_nack),
        .rsp_tout (rsp_tout),
        .rsp_try  (rsp_try),
        .busy     (busy),
        .st       (st),
        .ADR_COM  (ADR_COM),
        .adr_REG  (adr_REG),
        .dat_REG  (dat_REG),
        .en_tx    (en_tx),
        .err_AC   (err_AC),
        .RX_dat   (RX_dat)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Master model configuration (written by the main sequence only).
    logic [2:0]  m_nack = '0;
    logic [7:0]  m_rx = '0;
    bit          m_hang = 1'b0;
    int unsigned m_len = 4;
    int unsigned m_base = 0;
    int          txn_st_base = 0;

    // Written by the master model only.
    int unsigned att_seen = 0;
    int unsigned fall_cyc = 0;

    // Written by the start-pulse monitor only.
    int unsigned st_cyc_q[$];
    bit          st_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural master: en_tx rises one cycle after st, falls m_len cycles later with the result.
    initial begin
        forever begin
            @(negedge clk);
            if (st === 1'b1 && !m_hang) begin
                @(posedge clk);
                #1 en_tx = 1'b1;
                repeat (m_len) @(posedge clk);
                #1;
                err_AC   = ((att_seen - m_base) < 3) ? m_nack[att_seen - m_base] : 1'b0;
                RX_dat   = m_rx;
                en_tx    = 1'b0;
                fall_cyc = cyc;
                att_seen++;
            end
        end
    end

    // Start-pulse monitor: single-cycle, never with en_tx high, retries spaced by the bus-free gap.
    initial begin
        forever begin
            @(negedge clk);
            if (st === 1'b1) begin
                check("st_one_cycle", 32'(st_prev), 32'd0);
                check("st_en_tx_low", 32'(en_tx), 32'd0);
                if (st_cyc_q.size() > txn_st_base)
                    check("st_gap", 32'(cyc - fall_cyc >= GAP_CYC), 32'd1);
                st_cyc_q.push_back(cyc);
            end
            st_prev = st;
        end
    end

    task automatic wait_rdy();
        int unsigned t = 0;
        while (!req_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("req_rdy_wait", 32'(req_rdy), 32'd1);
    endtask

    task automatic issue(input bit rw, input logic [6:0] sadr, input logic [7:0] radr,
                         input logic [7:0] wdat, output int unsigned k);
        req_vld  = 1'b1;
        req_rw   = rw;
        req_sadr = sadr;
        req_radr = radr;
        req_wdat = wdat;
        k = cyc;
        @(posedge clk);
        #1;
        req_vld  = 1'b0;
        req_rw   = 1'($urandom);
        req_sadr = 7'($urandom);
        req_radr = 8'($urandom);
        req_wdat = 8'($urandom);
    endtask

    task automatic run_txn(input bit rw, input logic [6:0] sadr, input logic [7:0] radr,
                           input logic [7:0] wdat, input logic [7:0] rx, input logic [2:0] nmask,
                           input bit hang, input int unsigned len, input int unsigned hold);
        int unsigned k, t, rcyc, att_exp, st_base;
        bit          nack_exp;
        logic [7:0]  dat_exp;

        // Reference: attempts stop at the first ACK or after MAX_RETRY retries.
        att_exp = 0;
        for (int i = 0; i <= int'(MAX_RETRY); i++) begin
            att_exp = i + 1;
            if (!nmask[i]) break;
        end
        nack_exp = nmask[att_exp - 1];
        if (hang) begin
            att_exp  = 1;
            nack_exp = 1'b0;
        end
        dat_exp = (rw && !nack_exp && !hang) ? rx : 8'h00;

        m_nack = nmask;
        m_rx   = rx;
        m_hang = hang;
        m_len  = len;
        m_base = att_seen;

        @(negedge clk);
        wait_rdy();
        st_base     = st_cyc_q.size();
        txn_st_base = st_base;
        issue(rw, sadr, radr, wdat, k);

        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_vld && t < TOUT_CYC + 500);
        check("rsp_vld", 32'(rsp_vld), 32'd1);
        rcyc = cyc;

        check("st_count", 32'(st_cyc_q.size() - st_base), 32'(att_exp));
        if (st_cyc_q.size() > st_base)
            check("st_at_k1", st_cyc_q[st_base], k + 1);
        check("adr_com", 32'(ADR_COM), 32'({sadr, rw}));
        check("adr_reg", 32'(adr_REG), 32'(radr));
        if (!rw) check("dat_reg", 32'(dat_REG), 32'(wdat));
        if (hang) begin
            if (st_cyc_q.size() > st_base)
                check("tout_latency", rcyc - st_cyc_q[st_base], TOUT_CYC + 1);
        end else begin
            check("rsp_gap", 32'(rcyc - fall_cyc >= GAP_CYC), 32'd1);
        end

        for (int h = 0; h <= int'(hold); h++) begin
            check("rsp_vld_hold", 32'(rsp_vld), 32'd1);
            check("rsp_nack", 32'(rsp_nack), 32'(nack_exp));
            check("rsp_tout", 32'(rsp_tout), 32'(hang));
            check("rsp_try", 32'(rsp_try), att_exp - 1);
            check("rsp_dat", 32'(rsp_dat), 32'(dat_exp));
            if (h < int'(hold)) @(negedge clk);
        end

        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        check("rsp_vld_drop", 32'(rsp_vld), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned k, t;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_st", 32'(st), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        check("rst_rsp_try", 32'(rsp_try), 32'd0);
        check("rst_adr_com", 32'(ADR_COM), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", 32'(req_rdy), 32'd1);

        // Directed cases.
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 3'b000, 1'b0, 4, 0);
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 3'b000, 1'b0, 6, 1);
        run_txn(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 3'b111, 1'b0, 3, 0);
        run_txn(1'b1, 7'h2B, 8'h05, 8'h00, 8'h91, 3'b001, 1'b0, 5, 0);
        run_txn(1'b1, 7'h11, 8'h44, 8'h00, 8'h5A, 3'b000, 1'b1, 4, 5);

        // Reset while the master holds en_tx high.
        m_nack = 3'b000;
        m_rx   = 8'h77;
        m_hang = 1'b0;
        m_len  = 30;
        m_base = att_seen;
        @(negedge clk);
        wait_rdy();
        txn_st_base = st_cyc_q.size();
        issue(1'b1, 7'h33, 8'h66, 8'h00, k);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!en_tx && t < 50);
        check("rst_mid_en_up", 32'(en_tx), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_adr_com", 32'(ADR_COM), 32'd0);
        check("rst_mid_adr_reg", 32'(adr_REG), 32'd0);
        check("rst_mid_req_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        check("rst_mid_no_rsp", 32'(rsp_vld), 32'd0);
        t = 0;
        while (en_tx && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_en_fall", 32'(en_tx), 32'd0);
        check("rst_mid_req_rdy_after", 32'(req_rdy), 32'd1);
        run_txn(1'b0, 7'h50, 8'h10, 8'hC3, 8'h00, 3'b000, 1'b0, 2, 0);

        // Randomized transactions.
        for (int n = 0; n < 10; n++) begin
            run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), 1'b0, $urandom_range(1, 8), $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
